// File: rtl/regfile_scoreboard_pkg.sv
// Shared CPU widths for the register file / scoreboard slice.
package regfile_scoreboard_pkg;
  localparam int ID_W        = 8;
  localparam int DATA_W      = 32;
  localparam int MAXPEND_DEF = 3;

  typedef logic [ID_W-1:0]   reg_id_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_scoreboard_pend_counter.sv
// Saturating up/down pending-write counter with synchronous clear.
module pend_counter #(
  parameter int MAXPEND = 3,
  parameter int W       = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);
  // inc and dec together cancel, which also covers issue+retire at saturation
  always_ff @(posedge clk) begin
    if (reset || clear)                         cnt <= '0;
    else if (inc && !dec && cnt != W'(MAXPEND)) cnt <= cnt + W'(1);
    else if (dec && !inc && cnt != '0)          cnt <= cnt - W'(1);
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write-through bypass and per-register pending-write scoreboard.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int MAXPEND = MAXPEND_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_write_in,
  input  logic [ID_W-1:0]   wb_id_in,
  input  logic [DATA_W-1:0] wb_data_in,
  input  logic              issue_valid_in,
  input  logic [ID_W-1:0]   issue_id_in,
  input  logic              flush_in,
  input  logic [ID_W-1:0]   rd_id_a_in,
  input  logic [ID_W-1:0]   rd_id_b_in,
  output logic [DATA_W-1:0] rd_data_a_out,
  output logic [DATA_W-1:0] rd_data_b_out,
  output logic              busy_a_out,
  output logic              busy_b_out,
  output logic              stall_out
);
  localparam int CW = $clog2(MAXPEND + 1);

  reg_data_t                  regs [NREGS];
  logic [NREGS-1:0][CW-1:0]   pend;
  logic                       wb_ok, issue_ok;

  // id 0 and ids past the file are treated as "no register"
  function automatic logic in_range(input reg_id_t id);
    return (id != '0) && (32'(id) < NREGS);
  endfunction

  function automatic logic [CW-1:0] pend_of(input reg_id_t id);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 1; i < NREGS; i++)
      if (id == ID_W'(i)) c = pend[i];
    return c;
  endfunction

  function automatic reg_data_t read_port(input reg_id_t id);
    reg_data_t d;
    d = '0;
    if (in_range(id)) begin
      if (wb_ok && wb_id_in == id) d = wb_data_in;
      else if (!reset)
        for (int i = 1; i < NREGS; i++)
          if (id == ID_W'(i)) d = regs[i];
    end
    return d;
  endfunction

  // a same-cycle retire to the read id counts as already resolved
  function automatic logic busy_port(input reg_id_t id);
    logic hit;
    hit = wb_ok && (wb_id_in == id);
    return !reset && in_range(id) && (pend_of(id) > CW'(hit));
  endfunction

  assign wb_ok    = wb_write_in && in_range(wb_id_in);
  assign issue_ok = issue_valid_in && in_range(issue_id_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_ok) begin
      for (int i = 1; i < NREGS; i++)
        if (wb_id_in == ID_W'(i)) regs[i] <= wb_data_in;
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_pend
    if (i == 0) begin : g_zero
      assign pend[i] = '0;
    end else begin : g_cnt
      pend_counter #(.MAXPEND(MAXPEND), .W(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (flush_in),
        .inc   (issue_ok && issue_id_in == ID_W'(i)),
        .dec   (wb_ok && wb_id_in == ID_W'(i)),
        .cnt   (pend[i])
      );
    end
  end

  always_comb begin
    rd_data_a_out = read_port(rd_id_a_in);
    rd_data_b_out = read_port(rd_id_b_in);
    busy_a_out    = busy_port(rd_id_a_in);
    busy_b_out    = busy_port(rd_id_b_in);
    stall_out     = !reset && !flush_in && issue_ok
                    && (pend_of(issue_id_in) == CW'(MAXPEND))
                    && !(wb_ok && wb_id_in == issue_id_in);
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector bench for regfile_scoreboard.
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic        wb_write_in;
  logic [7:0]  wb_id_in;
  logic [31:0] wb_data_in;
  logic        issue_valid_in;
  logic [7:0]  issue_id_in;
  logic        flush_in;
  logic [7:0]  rd_id_a_in, rd_id_b_in;
  logic [31:0] rd_data_a_out, rd_data_b_out;
  logic        busy_a_out, busy_b_out, stall_out;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.NREGS(32), .MAXPEND(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .wb_write_in    (wb_write_in),
    .wb_id_in       (wb_id_in),
    .wb_data_in     (wb_data_in),
    .issue_valid_in (issue_valid_in),
    .issue_id_in    (issue_id_in),
    .flush_in       (flush_in),
    .rd_id_a_in     (rd_id_a_in),
    .rd_id_b_in     (rd_id_b_in),
    .rd_data_a_out  (rd_data_a_out),
    .rd_data_b_out  (rd_data_b_out),
    .busy_a_out     (busy_a_out),
    .busy_b_out     (busy_b_out),
    .stall_out      (stall_out)
  );

  typedef struct {
    logic        rst, wb, iv, fl;
    logic [7:0]  wid, iid, ra, rb;
    logic [31:0] wdata, ea, eb;
    logic        ba, bb, st;
  } vec_t;

  function automatic vec_t mk(int rst, int wb, int wid, int wdata, int iv, int iid, int fl,
                              int ra, int rb, int ea, int eb, int ba, int bb, int st);
    vec_t v;
    v.rst = (rst != 0); v.wb = (wb != 0); v.iv = (iv != 0); v.fl = (fl != 0);
    v.wid = 8'(wid); v.iid = 8'(iid); v.ra = 8'(ra); v.rb = 8'(rb);
    v.wdata = 32'(wdata); v.ea = 32'(ea); v.eb = 32'(eb);
    v.ba = (ba != 0); v.bb = (bb != 0); v.st = (st != 0);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // drive on the falling edge, sample 1 ns later, state commits on the next rising edge
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst; wb_write_in = v.wb; wb_id_in = v.wid; wb_data_in = v.wdata;
    issue_valid_in = v.iv; issue_id_in = v.iid; flush_in = v.fl;
    rd_id_a_in = v.ra; rd_id_b_in = v.rb;
    #1;
    n_vec++;
    chk({tag, ".rd_a"},  rd_data_a_out,        v.ea);
    chk({tag, ".rd_b"},  rd_data_b_out,        v.eb);
    chk({tag, ".busy_a"}, 32'(busy_a_out),     32'(v.ba));
    chk({tag, ".busy_b"}, 32'(busy_b_out),     32'(v.bb));
    chk({tag, ".stall"}, 32'(stall_out),       32'(v.st));
  endtask

  vec_t tbl[$];

  initial begin
    // rst wb wid wdata         iv iid fl  ra rb  ea            eb            ba bb st
    tbl.push_back(mk(0,1, 5,32'hDEADBEEF,0,0, 0,  5, 0, 32'hDEADBEEF,0,          0,0,0));
    tbl.push_back(mk(0,0, 0,0,           0,0, 0,  5, 5, 32'hDEADBEEF,32'hDEADBEEF,0,0,0));
    tbl.push_back(mk(0,1, 0,32'h1234,    0,0, 0,  0, 5, 0,           32'hDEADBEEF,0,0,0));
    tbl.push_back(mk(0,0, 0,0,           0,0, 0,  0, 5, 0,           32'hDEADBEEF,0,0,0));
    tbl.push_back(mk(0,1,40,32'hAAAA,    0,0, 0, 40, 8, 0,           0,           0,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,40,0,  8,40, 0,           0,           0,0,0));
    tbl.push_back(mk(0,0, 0,0,           0,0, 0,  8,40, 0,           0,           0,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,7, 0,  7, 0, 0,           0,           0,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,7, 0,  7, 0, 0,           0,           1,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,7, 0,  7, 0, 0,           0,           1,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,7, 0,  7, 0, 0,           0,           1,0,1));
    tbl.push_back(mk(0,1, 7,32'h70,      0,0, 0,  7, 0, 32'h70,      0,           1,0,0));
    tbl.push_back(mk(0,1, 7,32'h71,      0,0, 0,  7, 0, 32'h71,      0,           1,0,0));
    tbl.push_back(mk(0,1, 7,32'h72,      0,0, 0,  7, 0, 32'h72,      0,           0,0,0));
    tbl.push_back(mk(0,0, 0,0,           0,0, 0,  7, 0, 32'h72,      0,           0,0,0));
    tbl.push_back(mk(0,1, 7,32'h73,      0,0, 0,  7, 0, 32'h73,      0,           0,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,7, 0,  7, 0, 32'h73,      0,           0,0,0));
    tbl.push_back(mk(0,0, 0,0,           0,0, 0,  7, 0, 32'h73,      0,           1,0,0));
    tbl.push_back(mk(0,1, 7,32'h74,      0,0, 0,  7, 0, 32'h74,      0,           0,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,9, 0,  0, 9, 0,           0,           0,0,0));
    tbl.push_back(mk(0,1, 9,32'h99,      1,9, 0,  0, 9, 0,           32'h99,      0,0,0));
    tbl.push_back(mk(0,0, 0,0,           0,0, 0,  0, 9, 0,           32'h99,      0,1,0));
    tbl.push_back(mk(0,1, 9,32'h9A,      0,0, 0,  0, 9, 0,           32'h9A,      0,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,9, 0,  0, 9, 0,           32'h9A,      0,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,9, 0,  0, 9, 0,           32'h9A,      0,1,0));
    tbl.push_back(mk(0,0, 0,0,           1,9, 0,  0, 9, 0,           32'h9A,      0,1,0));
    tbl.push_back(mk(0,1, 9,32'h9B,      1,9, 0,  0, 9, 0,           32'h9B,      0,1,0));
    tbl.push_back(mk(0,0, 0,0,           1,9, 0,  0, 9, 0,           32'h9B,      0,1,1));
    tbl.push_back(mk(0,0, 0,0,           1,3, 0,  3, 4, 0,           0,           0,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,4, 0,  3, 4, 0,           0,           1,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,3, 0,  3, 4, 0,           0,           1,1,0));
    tbl.push_back(mk(0,0, 0,0,           1,4, 0,  3, 4, 0,           0,           1,1,0));
    tbl.push_back(mk(0,1, 4,32'h55,      1,3, 1,  3, 4, 0,           32'h55,      1,1,0));
    tbl.push_back(mk(0,0, 0,0,           0,0, 0,  3, 4, 0,           32'h55,      0,0,0));
    tbl.push_back(mk(0,0, 0,0,           0,0, 0,  9, 7, 32'h9B,      32'h74,      0,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,9, 0,  9, 0, 32'h9B,      0,           0,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,9, 0,  9, 0, 32'h9B,      0,           1,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,9, 0,  9, 0, 32'h9B,      0,           1,0,0));
    tbl.push_back(mk(0,0, 0,0,           1,9, 1,  9, 0, 32'h9B,      0,           1,0,0));
    tbl.push_back(mk(0,0, 0,0,           0,0, 0,  9, 0, 32'h9B,      0,           0,0,0));

    // reset, then every id reads zero and idle
    step(mk(1,0,0,0,0,0,0, 5,9, 0,0,0,0,0), "rst0");
    step(mk(1,0,0,0,0,0,0, 1,2, 0,0,0,0,0), "rst1");
    for (int i = 0; i < 32; i++)
      step(mk(0,0,0,0,0,0,0, i,31-i, 0,0,0,0,0), $sformatf("clr%0d", i));

    foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

    // reset mid-sequence with reg3 holding data, pend[3]=2 and a live writeback
    step(mk(0,1,3,32'h33,0,0,0, 3,5, 32'h33,32'hDEADBEEF,0,0,0), "mr0");
    step(mk(0,0,0,0,     1,3,0, 3,5, 32'h33,32'hDEADBEEF,0,0,0), "mr1");
    step(mk(0,0,0,0,     1,3,0, 3,5, 32'h33,32'hDEADBEEF,1,0,0), "mr2");
    step(mk(0,0,0,0,     0,0,0, 3,5, 32'h33,32'hDEADBEEF,1,0,0), "mr3");
    step(mk(1,1,3,32'h44,1,3,0, 3,5, 32'h44,0,           0,0,0), "mr4");
    step(mk(0,0,0,0,     0,0,0, 3,5, 0,     0,           0,0,0), "mr5");
    step(mk(0,0,0,0,     1,3,0, 3,5, 0,     0,           0,0,0), "mr6");
    step(mk(0,0,0,0,     0,0,0, 3,5, 0,     0,           1,0,0), "mr7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
